// File: rtl/dual_image_pkg.sv
// Shared state codes and default parameter values for the dual-stream image aligner.
package dual_image_pkg;

  localparam int DEF_INPUT_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH       = 16;
  localparam int DEF_MAX_SKEW         = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } align_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock skew buffer; pointers carry one extra MSB so full and empty are distinct.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en, rd_en;

  // A push into a full buffer is accepted only when a pop frees the slot on the same edge
  assign wr_en   = i_push && (!o_full || i_pop);
  assign rd_en   = i_pop && !o_empty;
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/dual_stream_align_ctrl.sv
// Aligns a master and a slave pixel stream whose frames start up to P_MAX_SKEW cycles apart,
// emitting matched pixel pairs from two skew FIFOs.
module dual_stream_align_ctrl
  import dual_image_pkg::*;
#(
  parameter int P_INPUT_DATA_WIDTH = DEF_INPUT_DATA_WIDTH,
  parameter int P_FIFO_DEPTH       = DEF_FIFO_DEPTH,
  parameter int P_MAX_SKEW         = DEF_MAX_SKEW
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_h_sync_m,
  input  logic                          i_v_sync_m,
  input  logic [P_INPUT_DATA_WIDTH-1:0] i_data_m,
  input  logic                          i_h_sync_s,
  input  logic                          i_v_sync_s,
  input  logic [P_INPUT_DATA_WIDTH-1:0] i_data_s,
  output logic                          o_v_sync,
  output logic                          o_h_sync,
  output logic [P_INPUT_DATA_WIDTH-1:0] o_data_m,
  output logic [P_INPUT_DATA_WIDTH-1:0] o_data_s,
  output logic                          o_frame_done,
  output logic                          o_err,
  output logic [1:0]                    o_state
);

  localparam int              CNT_W      = $clog2(P_MAX_SKEW + 1);
  localparam logic [CNT_W-1:0] SKEW_LIMIT = CNT_W'(P_MAX_SKEW);

  align_state_t                  state_p0, state_nxt;
  logic [CNT_W-1:0]              skew_cnt_p0, skew_cnt_nxt;
  logic                          lead_m_p0, lead_m_nxt;
  logic                          v_sync_m_p0, v_sync_s_p0;
  logic                          rise_m, rise_s;
  logic                          push_en, push_m, push_s, pop, flush, overflow;
  logic                          full_m, empty_m, full_s, empty_s;
  logic [P_INPUT_DATA_WIDTH-1:0] fifo_data_m, fifo_data_s;
  logic                          frame_done_nxt, err_nxt;
  logic                          h_sync_p1, frame_done_p1, err_p1;
  logic [P_INPUT_DATA_WIDTH-1:0] data_m_p1, data_s_p1;

  assign rise_m = i_v_sync_m && !v_sync_m_p0;
  assign rise_s = i_v_sync_s && !v_sync_s_p0;

  // Writes are enabled in SYNC/RUN and also on the IDLE edge that opens the frame
  always_comb begin
    push_en = 1'b0;
    case (state_p0)
      ST_IDLE:         push_en = rise_m || rise_s;
      ST_SYNC, ST_RUN: push_en = 1'b1;
      default:         push_en = 1'b0;
    endcase
  end

  assign push_m   = push_en && i_h_sync_m && i_v_sync_m;
  assign push_s   = push_en && i_h_sync_s && i_v_sync_s;
  assign pop      = (state_p0 == ST_RUN) && !empty_m && !empty_s;
  assign flush    = (state_p0 == ST_FLUSH);
  assign overflow = (push_m && full_m && !pop) || (push_s && full_s && !pop);

  always_comb begin
    state_nxt      = state_p0;
    skew_cnt_nxt   = skew_cnt_p0;
    lead_m_nxt     = lead_m_p0;
    frame_done_nxt = 1'b0;
    err_nxt        = 1'b0;
    case (state_p0)
      ST_IDLE: begin
        skew_cnt_nxt = '0;
        if (rise_m && rise_s) begin
          state_nxt = ST_RUN;
        end else if (rise_m || rise_s) begin
          state_nxt    = ST_SYNC;
          skew_cnt_nxt = CNT_W'(1);
          lead_m_nxt   = rise_m;
        end
      end
      ST_SYNC: begin
        skew_cnt_nxt = skew_cnt_p0 + CNT_W'(1);
        if (skew_cnt_p0 == SKEW_LIMIT) begin
          state_nxt = ST_FLUSH;
          err_nxt   = 1'b1;
        end else if (lead_m_p0 ? rise_s : rise_m) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_v_sync_m && !i_v_sync_s && empty_m && empty_s) begin
          state_nxt      = ST_IDLE;
          frame_done_nxt = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (!i_v_sync_m && !i_v_sync_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A dropped pixel breaks pairing for the rest of the frame
    if (overflow) begin
      state_nxt      = ST_FLUSH;
      err_nxt        = 1'b1;
      frame_done_nxt = 1'b0;
    end
  end

  // Stage p0: control state and v_sync history; stage p1: registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_p0      <= ST_IDLE;
      skew_cnt_p0   <= '0;
      lead_m_p0     <= 1'b0;
      v_sync_m_p0   <= 1'b0;
      v_sync_s_p0   <= 1'b0;
      h_sync_p1     <= 1'b0;
      data_m_p1     <= '0;
      data_s_p1     <= '0;
      frame_done_p1 <= 1'b0;
      err_p1        <= 1'b0;
    end else begin
      state_p0      <= state_nxt;
      skew_cnt_p0   <= skew_cnt_nxt;
      lead_m_p0     <= lead_m_nxt;
      v_sync_m_p0   <= i_v_sync_m;
      v_sync_s_p0   <= i_v_sync_s;
      h_sync_p1     <= pop;
      data_m_p1     <= pop ? fifo_data_m : '0;
      data_s_p1     <= pop ? fifo_data_s : '0;
      frame_done_p1 <= frame_done_nxt;
      err_p1        <= err_nxt;
    end
  end

  sync_fifo #(
    .WIDTH (P_INPUT_DATA_WIDTH),
    .DEPTH (P_FIFO_DEPTH)
  ) u_fifo_m (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_m),
    .i_data  (i_data_m),
    .i_pop   (pop),
    .i_flush (flush),
    .o_data  (fifo_data_m),
    .o_full  (full_m),
    .o_empty (empty_m)
  );

  sync_fifo #(
    .WIDTH (P_INPUT_DATA_WIDTH),
    .DEPTH (P_FIFO_DEPTH)
  ) u_fifo_s (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_s),
    .i_data  (i_data_s),
    .i_pop   (pop),
    .i_flush (flush),
    .o_data  (fifo_data_s),
    .o_full  (full_s),
    .o_empty (empty_s)
  );

  assign o_v_sync     = (state_p0 == ST_RUN);
  assign o_state      = state_p0;
  assign o_h_sync     = h_sync_p1;
  assign o_data_m     = data_m_p1;
  assign o_data_s     = data_s_p1;
  assign o_frame_done = frame_done_p1;
  assign o_err        = err_p1;

endmodule

// File: tb/tb_dual_stream_align_ctrl.sv
// Randomized bench for dual_stream_align_ctrl: frames are scripted per cycle, outputs captured,
// and compared against a pair-matching reference model derived from stream timing.
module tb_dual_stream_align_ctrl;

  localparam int W    = 8;
  localparam int NMAX = 128;
  localparam int TW   = 6 + 2 * W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         h_m, v_m, h_s, v_s;
  logic [W-1:0] d_m, d_s;
  logic         o_v_sync, o_h_sync, o_frame_done, o_err;
  logic [W-1:0] o_data_m, o_data_s;
  logic [1:0]   o_state;

  always #5 clk = ~clk;

  dual_stream_align_ctrl #(
    .P_INPUT_DATA_WIDTH (W),
    .P_FIFO_DEPTH       (16),
    .P_MAX_SKEW         (64)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_h_sync_m   (h_m),
    .i_v_sync_m   (v_m),
    .i_data_m     (d_m),
    .i_h_sync_s   (h_s),
    .i_v_sync_s   (v_s),
    .i_data_s     (d_s),
    .o_v_sync     (o_v_sync),
    .o_h_sync     (o_h_sync),
    .o_data_m     (o_data_m),
    .o_data_s     (o_data_s),
    .o_frame_done (o_frame_done),
    .o_err        (o_err),
    .o_state      (o_state)
  );

  // Per-cycle stimulus script, captured outputs and model expectations
  bit           st_rst [NMAX], st_vm [NMAX], st_hm [NMAX], st_vs [NMAX], st_hs [NMAX];
  logic [W-1:0] st_dm [NMAX], st_ds [NMAX];
  int           n_cyc;
  bit           cap_vs [NMAX], cap_h [NMAX], cap_done [NMAX], cap_err [NMAX];
  logic [1:0]   cap_state [NMAX];
  logic [W-1:0] cap_dm [NMAX], cap_ds [NMAX];
  bit           ex_vs [NMAX], ex_h [NMAX], ex_done [NMAX];
  logic [1:0]   ex_state [NMAX];
  logic [W-1:0] ex_dm [NMAX], ex_ds [NMAX];
  int           ex_pairs;
  int           checks = 0;
  int           errors = 0;

  task automatic clear_stim();
    for (int k = 0; k < NMAX; k++) begin
      st_rst[k] = 1'b0; st_vm[k] = 1'b0; st_hm[k] = 1'b0; st_vs[k] = 1'b0; st_hs[k] = 1'b0;
      st_dm[k] = '0; st_ds[k] = '0;
    end
  endtask

  task automatic play();
    for (int k = 0; k < n_cyc; k++) begin
      @(negedge clk);
      rst_n = !st_rst[k];
      v_m = st_vm[k]; h_m = st_hm[k]; d_m = st_dm[k];
      v_s = st_vs[k]; h_s = st_hs[k]; d_s = st_ds[k];
      @(posedge clk);
      #1;
      cap_vs[k] = o_v_sync; cap_h[k] = o_h_sync; cap_done[k] = o_frame_done;
      cap_err[k] = o_err; cap_state[k] = o_state; cap_dm[k] = o_data_m; cap_ds[k] = o_data_s;
    end
  endtask

  // 16-pixel frame; slave pixel times are the master's shifted by skew (negative = slave first)
  task automatic gen_frame(input int skew, input int max_gap, input bit ramp);
    int rm, rs, t, tail_m, tail_s;
    clear_stim();
    rm = 3 + ((skew < 0) ? -skew : 0);
    rs = rm + skew;
    t  = 0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) t += 1 + int'($urandom_range(max_gap, 0));
      st_hm[rm + t] = 1'b1;
      st_hs[rs + t] = 1'b1;
      st_dm[rm + t] = ramp ? W'(j) : W'($urandom);
      st_ds[rs + t] = ramp ? W'(j + 1) : W'($urandom);
    end
    tail_m = int'($urandom_range(max_gap, 0));
    tail_s = int'($urandom_range(max_gap, 0));
    for (int k = rm; k <= rm + t + tail_m; k++) st_vm[k] = 1'b1;
    for (int k = rs; k <= rs + t + tail_s; k++) st_vs[k] = 1'b1;
    n_cyc = ((rm > rs) ? rm : rs) + t + max_gap + 24;
  endtask

  // Pair i leaves one edge after the later of its two writes, one pair per cycle at most;
  // the aligned window runs from the later frame start until both streams end and drain.
  task automatic build_model();
    int rm, rs, start, run, prev, vl, ex_exit, t;
    int tm[$];
    int ts[$];
    rm = -1; rs = -1;
    for (int k = 0; k < NMAX; k++) begin
      ex_vs[k] = 1'b0; ex_h[k] = 1'b0; ex_done[k] = 1'b0; ex_state[k] = 2'd0;
      ex_dm[k] = '0; ex_ds[k] = '0;
      if (rm < 0 && st_vm[k] && (k == 0 || !st_vm[k-1])) rm = k;
      if (rs < 0 && st_vs[k] && (k == 0 || !st_vs[k-1])) rs = k;
    end
    start = (rm < rs) ? rm : rs;
    run   = (rm > rs) ? rm : rs;
    for (int k = start; k < n_cyc; k++) begin
      if (st_vm[k] && st_hm[k]) tm.push_back(k);
      if (st_vs[k] && st_hs[k]) ts.push_back(k);
    end
    prev = -1;
    for (int i = 0; i < tm.size(); i++) begin
      t = ((tm[i] > ts[i]) ? tm[i] : ts[i]) + 1;
      if (t <= prev) t = prev + 1;
      ex_h[t] = 1'b1; ex_dm[t] = st_dm[tm[i]]; ex_ds[t] = st_ds[ts[i]];
      prev = t;
    end
    ex_pairs = tm.size();
    vl = run + 1;
    while (vl < NMAX - 1 && (st_vm[vl] || st_vs[vl])) vl++;
    ex_exit = (vl > prev + 1) ? vl : prev + 1;
    ex_done[ex_exit] = 1'b1;
    for (int k = 0; k < NMAX; k++) begin
      if (k < start)        ex_state[k] = 2'd0;
      else if (k < run)     ex_state[k] = 2'd1;
      else if (k < ex_exit) ex_state[k] = 2'd2;
      else                  ex_state[k] = 2'd0;
      ex_vs[k] = (k >= run) && (k < ex_exit);
    end
  endtask

  task automatic test_reset();
    logic [TW-1:0] got;
    clear_stim();
    n_cyc = 8;
    for (int k = 0; k < 4; k++) begin
      st_rst[k] = 1'b1;
      st_vm[k] = 1'b1; st_hm[k] = 1'b1; st_vs[k] = 1'b1; st_hs[k] = 1'b1;
      st_dm[k] = W'($urandom); st_ds[k] = W'($urandom);
    end
    play();
    for (int k = 0; k < n_cyc; k++) begin
      got = {cap_vs[k], cap_h[k], cap_done[k], cap_err[k], cap_state[k], cap_dm[k], cap_ds[k]};
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%h exp=0", k, got);
      end
    end
  endtask

  task automatic test_alignment(input int n_scen);
    logic [TW-1:0] got, exp;
    int pairs, dones;
    for (int s = 0; s < n_scen; s++) begin
      if (s == 0)      gen_frame(0, 0, 1'b1);
      else if (s == 1) gen_frame(10, 0, 1'b1);
      else             gen_frame(int'($urandom_range(24, 0)) - 12, 2, 1'b0);
      build_model();
      play();
      pairs = 0; dones = 0;
      for (int k = 0; k < n_cyc; k++) begin
        got = {cap_vs[k], cap_h[k], cap_done[k], cap_err[k], cap_state[k], cap_dm[k], cap_ds[k]};
        exp = {ex_vs[k], ex_h[k], ex_done[k], 1'b0, ex_state[k], ex_dm[k], ex_ds[k]};
        pairs += int'(cap_h[k]);
        dones += int'(cap_done[k]);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL align_s%0d cyc=%0d got=%h exp=%h", s, k, got, exp);
        end
      end
      checks++;
      if (pairs != 16 || dones != 1 || ex_pairs != 16) begin
        errors++;
        $display("FAIL align_count_s%0d got pairs=%0d dones=%0d exp pairs=16 dones=1", s, pairs, dones);
      end
    end
  endtask

  task automatic test_timeout();
    logic [TW-1:0] got, exp;
    logic [1:0] st;
    clear_stim();
    n_cyc = 90;
    for (int k = 3; k <= 82; k++) st_vm[k] = 1'b1;
    play();
    for (int k = 0; k < n_cyc; k++) begin
      st  = (k < 3) ? 2'd0 : (k < 67) ? 2'd1 : (k < 83) ? 2'd3 : 2'd0;
      got = {cap_vs[k], cap_h[k], cap_done[k], cap_err[k], cap_state[k], cap_dm[k], cap_ds[k]};
      exp = {1'b0, 1'b0, 1'b0, (k == 67), st, W'(0), W'(0)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [TW-1:0] got, exp;
    logic [1:0] st;
    clear_stim();
    n_cyc = 55;
    for (int k = 3; k <= 26; k++) begin
      st_vm[k] = 1'b1; st_hm[k] = 1'b1; st_dm[k] = W'($urandom);
    end
    for (int k = 23; k <= 46; k++) begin
      st_vs[k] = 1'b1; st_hs[k] = 1'b1; st_ds[k] = W'($urandom);
    end
    play();
    for (int k = 0; k < n_cyc; k++) begin
      st  = (k < 3) ? 2'd0 : (k < 19) ? 2'd1 : (k < 47) ? 2'd3 : 2'd0;
      got = {cap_vs[k], cap_h[k], cap_done[k], cap_err[k], cap_state[k], cap_dm[k], cap_ds[k]};
      exp = {1'b0, 1'b0, 1'b0, (k == 19), st, W'(0), W'(0)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL overflow cyc=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [TW-1:0] got, exp;
    gen_frame(0, 0, 1'b1);
    n_cyc = 30;
    st_rst[10] = 1'b1;
    for (int k = 11; k < NMAX; k++) begin
      st_vm[k] = 1'b0; st_hm[k] = 1'b0; st_vs[k] = 1'b0; st_hs[k] = 1'b0;
      st_dm[k] = '0; st_ds[k] = '0;
    end
    play();
    got = {cap_vs[9], cap_h[9], cap_done[9], cap_err[9], cap_state[9], cap_dm[9], cap_ds[9]};
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 2'd2, W'(5), W'(6)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL midreset_before cyc=9 got=%h exp=%h", got, exp);
    end
    for (int k = 10; k < n_cyc; k++) begin
      got = {cap_vs[k], cap_h[k], cap_done[k], cap_err[k], cap_state[k], cap_dm[k], cap_ds[k]};
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL midreset_after cyc=%0d got=%h exp=0", k, got);
      end
    end
    gen_frame(int'($urandom_range(8, 0)) - 4, 1, 1'b0);
    build_model();
    play();
    for (int k = 0; k < n_cyc; k++) begin
      got = {cap_vs[k], cap_h[k], cap_done[k], cap_err[k], cap_state[k], cap_dm[k], cap_ds[k]};
      exp = {ex_vs[k], ex_h[k], ex_done[k], 1'b0, ex_state[k], ex_dm[k], ex_ds[k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL midreset_recover cyc=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    h_m = 1'b0; v_m = 1'b0; d_m = '0;
    h_s = 1'b0; v_s = 1'b0; d_s = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_alignment(10);
    test_timeout();
    test_overflow();
    test_reset_midframe();
    test_alignment(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
